// File: rtl/dcm_prog_sequencer.sv
// -----------------------------------------------------------------------------
// dcm_prog_sequencer
//
// Reprograms a DCM_CLKGEN clock generator whenever the frequency-control logic
// asks for a new M/D pair. Each request is sent to the DCM as three serial
// commands on PROGEN/PROGDATA:
//   LoadD : 1, 0, D[0]..D[7]
//   LoadM : 1, 1, M[0]..M[7]
//   GO    : a single PROGEN strobe
// After GO the block waits for PROGDONE. If PROGDONE does not arrive in time,
// the same values are re-sent a limited number of times before an error is
// flagged. Requests that arrive while a reprogram is in flight go into a
// one-entry pending slot, where a newer request replaces an older one.
//
// Parameters:
//   TIMEOUT_W  width of the PROGDONE wait counter (timeout after 2^TIMEOUT_W)
//   MAX_RETRY  number of re-sends after a timeout before the error flag is set
//   INIT_M     reset value of cur_m (encoded M-1)
//   INIT_D     reset value of cur_d (encoded D-1)
//
// Ports:
//   clk         programming clock
//   reset       synchronous, active-high reset
//   req_valid   single-cycle request strobe
//   req_m       requested multiplier, encoded M-1 (must be nonzero)
//   req_d       requested divider, encoded D-1
//   prog_data   to DCM PROGDATA (registered)
//   prog_en     to DCM PROGEN (registered)
//   prog_done   from DCM PROGDONE
//   busy        high from acceptance until completion or error
//   done_pulse  one-cycle strobe on successful completion
//   error       sticky error flag, cleared by the next accepted request
//   cur_m       last successfully applied M field
//   cur_d       last successfully applied D field
// -----------------------------------------------------------------------------
module dcm_prog_sequencer #(
    parameter int         TIMEOUT_W = 16,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] INIT_M    = 8'd1,
    parameter logic [7:0] INIT_D    = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_m,
    input  logic [7:0] req_d,
    output logic       prog_data,
    output logic       prog_en,
    input  logic       prog_done,
    output logic       busy,
    output logic       done_pulse,
    output logic       error,
    output logic [7:0] cur_m,
    output logic [7:0] cur_d
);

    // Retry counter must be able to hold MAX_RETRY; the +2 keeps the width
    // at least one bit even when MAX_RETRY is zero.
    localparam int             RW          = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0]  MAX_RETRY_C = RW'(MAX_RETRY);

    localparam logic [3:0] LOAD_LAST = 4'd9;
    localparam logic [3:0] GAP_LAST  = 4'd1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        GAP1,
        LOAD_M,
        GAP2,
        GO,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t               state, state_nx;
    logic [3:0]           bit_cnt, bit_cnt_nx;
    logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic [RW-1:0]        retry_cnt, retry_cnt_nx;
    logic                 seen_low, seen_low_nx;

    logic [7:0]           work_m, work_m_nx;
    logic [7:0]           work_d, work_d_nx;
    logic [7:0]           pend_m, pend_m_nx;
    logic [7:0]           pend_d, pend_d_nx;
    logic                 pend_valid, pend_valid_nx;
    logic                 bad_req, bad_req_nx;

    logic                 error_nx;
    logic                 done_nx;
    logic                 busy_nx;
    logic [7:0]           cur_m_nx, cur_d_nx;
    logic                 prog_en_nx, prog_data_nx;
    logic [2:0]           bit_idx;

    // State and output registers. Every output is loaded from its next-cycle
    // value, so the DCM sees glitch-free PROGEN/PROGDATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            seen_low   <= 1'b0;
            work_m     <= '0;
            work_d     <= '0;
            pend_m     <= '0;
            pend_d     <= '0;
            pend_valid <= 1'b0;
            bad_req    <= 1'b0;
            prog_en    <= 1'b0;
            prog_data  <= 1'b0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            error      <= 1'b0;
            cur_m      <= INIT_M;
            cur_d      <= INIT_D;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            tmo_cnt    <= tmo_cnt_nx;
            retry_cnt  <= retry_cnt_nx;
            seen_low   <= seen_low_nx;
            work_m     <= work_m_nx;
            work_d     <= work_d_nx;
            pend_m     <= pend_m_nx;
            pend_d     <= pend_d_nx;
            pend_valid <= pend_valid_nx;
            bad_req    <= bad_req_nx;
            prog_en    <= prog_en_nx;
            prog_data  <= prog_data_nx;
            busy       <= busy_nx;
            done_pulse <= done_nx;
            error      <= error_nx;
            cur_m      <= cur_m_nx;
            cur_d      <= cur_d_nx;
        end
    end

    // Next-state logic for the sequencer, the pending slot and the status
    // registers.
    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        tmo_cnt_nx    = tmo_cnt;
        retry_cnt_nx  = retry_cnt;
        seen_low_nx   = seen_low;
        work_m_nx     = work_m;
        work_d_nx     = work_d;
        pend_m_nx     = pend_m;
        pend_d_nx     = pend_d;
        pend_valid_nx = pend_valid;
        bad_req_nx    = bad_req;
        error_nx      = error;
        cur_m_nx      = cur_m;
        cur_d_nx      = cur_d;
        done_nx       = 1'b0;

        // Outside IDLE, a request only updates the pending slot. An invalid
        // request leaves the slot alone and is reported when the current
        // operation ends.
        if ((state != IDLE) && req_valid) begin
            if (req_m != 8'd0) begin
                pend_valid_nx = 1'b1;
                pend_m_nx     = req_m;
                pend_d_nx     = req_d;
            end else begin
                bad_req_nx = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (req_valid && (req_m == 8'd0)) begin
                    error_nx = 1'b1;
                end else if (req_valid || pend_valid) begin
                    // A fresh strobe is newer than anything left in the
                    // pending slot after an aborted operation, so it wins.
                    work_m_nx     = req_valid ? req_m : pend_m;
                    work_d_nx     = req_valid ? req_d : pend_d;
                    pend_valid_nx = 1'b0;
                    retry_cnt_nx  = '0;
                    error_nx      = 1'b0;
                    bit_cnt_nx    = '0;
                    state_nx      = LOAD_D;
                end
            end

            LOAD_D: begin
                if (bit_cnt == LOAD_LAST) begin
                    bit_cnt_nx = '0;
                    state_nx   = GAP1;
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end

            GAP1: begin
                if (bit_cnt == GAP_LAST) begin
                    bit_cnt_nx = '0;
                    state_nx   = LOAD_M;
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end

            LOAD_M: begin
                if (bit_cnt == LOAD_LAST) begin
                    bit_cnt_nx = '0;
                    state_nx   = GAP2;
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end

            GAP2: begin
                if (bit_cnt == GAP_LAST) begin
                    bit_cnt_nx = '0;
                    state_nx   = GO;
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end

            GO: begin
                tmo_cnt_nx  = '0;
                seen_low_nx = 1'b0;
                state_nx    = WAIT_DONE;
            end

            WAIT_DONE: begin
                // PROGDONE may still be high from the previous operation, so
                // only a low-then-high sequence counts as completion.
                tmo_cnt_nx = tmo_cnt + TIMEOUT_W'(1);
                if (!prog_done) begin
                    seen_low_nx = 1'b1;
                end
                if (seen_low && prog_done) begin
                    state_nx = FINISH;
                end else if (tmo_cnt == '1) begin
                    if (retry_cnt < MAX_RETRY_C) begin
                        retry_cnt_nx = retry_cnt + RW'(1);
                        bit_cnt_nx   = '0;
                        state_nx     = LOAD_D;
                    end else begin
                        error_nx   = 1'b1;
                        bad_req_nx = 1'b0;
                        state_nx   = IDLE;
                    end
                end
            end

            FINISH: begin
                cur_m_nx   = work_m;
                cur_d_nx   = work_d;
                done_nx    = 1'b1;
                error_nx   = error | bad_req_nx;
                bad_req_nx = 1'b0;
                // pend_*_nx already includes a request strobed in this very
                // cycle, so it is chained without passing through IDLE.
                if (pend_valid_nx) begin
                    work_m_nx     = pend_m_nx;
                    work_d_nx     = pend_d_nx;
                    pend_valid_nx = 1'b0;
                    retry_cnt_nx  = '0;
                    bit_cnt_nx    = '0;
                    state_nx      = LOAD_D;
                end else begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // PROGEN/PROGDATA for the coming cycle, decoded from the next state and
    // bit position so the registered outputs line up with the state.
    always_comb begin
        prog_en_nx   = 1'b0;
        prog_data_nx = 1'b0;
        bit_idx      = 3'(bit_cnt_nx - 4'd2);

        case (state_nx)
            LOAD_D: begin
                prog_en_nx = 1'b1;
                if (bit_cnt_nx == 4'd0) begin
                    prog_data_nx = 1'b1;
                end else if (bit_cnt_nx == 4'd1) begin
                    prog_data_nx = 1'b0;
                end else begin
                    prog_data_nx = work_d_nx[bit_idx];
                end
            end

            LOAD_M: begin
                prog_en_nx = 1'b1;
                if (bit_cnt_nx < 4'd2) begin
                    prog_data_nx = 1'b1;
                end else begin
                    prog_data_nx = work_m_nx[bit_idx];
                end
            end

            GO: begin
                prog_en_nx = 1'b1;
            end

            default: begin
                prog_en_nx   = 1'b0;
                prog_data_nx = 1'b0;
            end
        endcase
    end

    assign busy_nx = (state_nx != IDLE);

endmodule

// File: doc/dcm_prog_sequencer.md
# dcm_prog_sequencer

Sequences reprogramming of the DCM_CLKGEN core clock generator from frequency-change requests issued by the bruteforcer's frequency-control logic. It serializes the LoadD / LoadM / GO commands onto PROGDATA/PROGEN, waits for PROGDONE, retries on timeout, and coalesces requests that arrive while a reprogram is in flight. It sits in the programming clock domain, between the bruteforcer's `freq_control` output and the programmable PLL.

## Interface
- `TIMEOUT_W`, 16: width of the PROGDONE wait counter; timeout after 2^TIMEOUT_W cycles.
- `MAX_RETRY`, 2: number of re-sends after a timeout before an error is flagged.
- `INIT_M`, 8'd1: reset value of `cur_m` (encoded M-1).
- `INIT_D`, 8'd0: reset value of `cur_d` (encoded D-1).

Ports:
- `clk`  in  1  programming clock (100 MHz domain).
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  single-cycle request strobe.
- `req_m`  in  8  encoded multiplier (M-1); must be nonzero.
- `req_d`  in  8  encoded divider (D-1).
- `prog_data`  out  1  to DCM PROGDATA.
- `prog_en`  out  1  to DCM PROGEN.
- `prog_done`  in  1  from DCM PROGDONE.
- `busy`  out  1  high from acceptance until completion or error.
- `done_pulse`  out  1  one cycle on successful completion.
- `error`  out  1  sticky; cleared by the next accepted request.
- `cur_m`  out  8  last successfully applied M field.
- `cur_d`  out  8  last successfully applied D field.

## Operation
- States: IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, FINISH.
- **IDLE:** on `req_valid` with `req_m!=0`, latch M/D into the working register, clear `error`, set `busy`, and go to LOAD_D. If `req_m==0`, set `error`, send nothing, and stay in IDLE.
- **LOAD_D:** 10 cycles, `prog_en=1`. `prog_data` sequence is 1, 0, then D[0]..D[7] (LSB first).
- **GAP1/GAP2:** 2 cycles each, `prog_en=0`, `prog_data=0`.
- **LOAD_M:** 10 cycles, `prog_en=1`. `prog_data` sequence is 1, 1, then M[0]..M[7].
- **GO:** 1 cycle, `prog_en=1`, `prog_data=0`.
- **WAIT_DONE:** `prog_en=0`. Completion requires `prog_done` sampled low at least once and then sampled high; a `prog_done` that is high and never drops does not complete. On completion, go to FINISH.
- **FINISH:** load `cur_m`/`cur_d` from the working register and pulse `done_pulse`. If pending is valid, move pending to working and go to LOAD_D. Otherwise clear `busy` and go to IDLE.
- **Timeout:** counter reaches 2^TIMEOUT_W-1 in WAIT_DONE.
  - If retry count < MAX_RETRY, increment it and restart at LOAD_D with the same values.
  - Otherwise set `error`, drop the working values, clear `busy`, and go to IDLE. A valid pending request is then accepted next cycle as if freshly issued.
- **Pending slot:** one entry. A `req_valid` while not in IDLE overwrites pending (last request wins). A request with `req_m==0` while busy is dropped and sets `error` only at the end of the current operation.
- A `req_valid` arriving in the same cycle as FINISH is written to pending and issued by that same FINISH decision.
- Retry count resets on every new working request.

## Timing
- All outputs are registered.
- Reset values: `prog_en=0`, `prog_data=0`, `busy=0`, `done_pulse=0`, `error=0`, `cur_m=INIT_M`, `cur_d=INIT_D`. Pending is invalid.
- Request sampled at cycle t (IDLE):
  - `busy` is high at t+1.
  - LOAD_D occupies t+1..t+10, GAP1 t+11..t+12, LOAD_M t+13..t+22, GAP2 t+23..t+24, GO t+25.
  - WAIT_DONE starts at t+26.
- The timeout counter starts at 0 in the first WAIT_DONE cycle.
- `done_pulse` and the `cur_m`/`cur_d` update occur in the cycle after `prog_done` is sampled high (the FINISH cycle + 1 register stage). `busy` falls in the same cycle.
- A back-to-back pending request starts LOAD_D's first bit the cycle after FINISH. Minimum spacing between GO strobes is 26 cycles plus the PROGDONE latency.
- Reset mid-sequence: `prog_en` is low in the cycle after reset is sampled, pending is discarded, and `cur_*` return to INIT values.

## Test plan
- **Single request:** `req_m=8'h13`, `req_d=8'h04`. The PROGEN trace is 1111111111 00 1111111111 00 1. PROGDATA is 1,0,0,0,1,0,0,0,0,0 / 1,1,1,1,0,0,1,0,0,0. The DCM model drops PROGDONE 3 cycles after GO and raises it 20 cycles later. Expect `done_pulse` once, `cur_m=8'h13`, `cur_d=8'h04`.
- **Coalescing:** requests A, B, C issued during A's LOAD_M. Expect sequences for A then C only, two `done_pulse`s, and final `cur_m/cur_d=C`.
- **Timeout/retry:** `TIMEOUT_W=6`, PROGDONE stuck high. Expect 3 full sequences (1+MAX_RETRY), then `error=1`, `busy=0`, `cur_*` unchanged.
- **Invalid request:** `req_m=0` in IDLE. Expect `prog_en` stays 0, `error=1`, `busy=0`. A following valid request clears `error`.
- **Reset mid-operation:** assert reset in LOAD_M cycle 5 with a pending request present. Expect `prog_en=0` next cycle, no further sequence, and `cur_m=INIT_M`.
- **Simultaneous events:** `req_valid` in the FINISH cycle. Expect the new sequence to start the next cycle with no IDLE cycle and `busy` held high.
